// File: rtl/board_arb_pkg.sv
// -----------------------------------------------------------------------------
// board_arb_pkg
// Shared definitions for the board-state RAM arbiter:
//   - default raster geometry (640x480 visible inside an 800x525 total frame)
//   - default board RAM geometry (16x16 cells, 4-bit cell codes)
//   - write-buffer state encoding
//   - cell-code type and a raster helper
// Optional feature macro used by the arbiter: BOARD_ARB_VBLANK_ONLY_EN
// -----------------------------------------------------------------------------
package board_arb_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  typedef logic [DATA_W_DEF-1:0] cell_t;

  // True while the raster is inside the visible area.
  function automatic logic in_active(input logic [15:0] h, input logic [15:0] v,
                                     input int h_act, input int v_act);
    return (h < 16'(h_act)) && (v < 16'(v_act));
  endfunction

endpackage

// File: rtl/board_wr_buffer.sv
// -----------------------------------------------------------------------------
// board_wr_buffer
// One-entry holding buffer for game-logic writes into the board RAM.
// A write offer is taken with a ready/valid handshake while EMPTY; the entry
// is released by the arbiter's commit strobe. Capture only happens in EMPTY
// and commit only in FULL, so the two can never coincide.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   i_wr_valid in   write offer
//   i_wr_addr  in   write address
//   i_wr_data  in   write data
//   o_wr_ready out  buffer can accept (EMPTY and not in reset)
//   i_commit   in   arbiter consumed the entry this cycle
//   o_full     out  entry is pending
//   o_addr     out  pending address
//   o_data     out  pending data
// -----------------------------------------------------------------------------
module board_wr_buffer
  import board_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_commit,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  buf_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Ready is gated by reset so nothing upstream sees a handshake while the
  // buffer is being cleared.
  assign o_wr_ready = (r_state == BUF_EMPTY) && !rst;
  assign o_full     = (r_state == BUF_FULL);
  assign o_addr     = r_addr;
  assign o_data     = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (i_wr_valid) begin
            r_addr  <= i_wr_addr;
            r_data  <= i_wr_data;
            r_state <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (i_commit) r_state <= BUF_EMPTY;
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// -----------------------------------------------------------------------------
// board_mem_arbiter
// Shares the single-port, synchronous-read board RAM between the VGA cell
// renderer (reads) and the minesweeper game logic (writes). Reads always win;
// a game write sits in a one-entry buffer until a read-free cycle inside its
// write window.
//
// Config macro: BOARD_ARB_VBLANK_ONLY_EN
//   defined   -> writes commit only during vertical blanking (no tearing)
//   undefined -> writes commit on any cycle without a read request
//
// Ports:
//   clk_25MHz   in   pixel clock
//   rst         in   asynchronous active-high reset
//   h_count     in   horizontal raster count 0..799
//   v_count     in   vertical raster count 0..524
//   rd_req      in   renderer read request
//   rd_addr     in   renderer cell address
//   rd_valid    out  rd_data valid (2 cycles after rd_req)
//   rd_data     out  read data, straight from mem_rdata
//   wr_valid    in   game write offer
//   wr_addr     in   game write address
//   wr_data     in   game write data
//   wr_ready    out  write buffer can accept
//   mem_addr    out  RAM address (registered)
//   mem_we      out  RAM write enable (registered)
//   mem_wdata   out  RAM write data (registered)
//   mem_rdata   in   RAM read data, one cycle after mem_addr
//   frame_start out  one-cycle pulse after raster origin is seen
// -----------------------------------------------------------------------------
module board_mem_arbiter
  import board_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
)(
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic [15:0]       h_count,
  input  logic [15:0]       v_count,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_start
);

  // Stage 0: address on the RAM port; stage 1: data back from the RAM.
  localparam int RD_STAGES = 2;

  logic                 w_win;
  logic                 w_grant_wr;
  logic                 w_buf_full;
  logic [ADDR_W-1:0]    w_buf_addr;
  logic [DATA_W-1:0]    w_buf_data;

  logic [RD_STAGES-1:0] r_vld_pipe;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic                 r_mem_we;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_frame_start;

  // ---------------------------------------------------------------------------
  // Write window, recomputed every cycle straight from the raster inputs so a
  // counter wrap needs no extra state.
  // ---------------------------------------------------------------------------
`ifdef BOARD_ARB_VBLANK_ONLY_EN
  assign w_win = (v_count >= 16'(V_ACTIVE));
`else
  logic w_active;
  assign w_active = in_active(h_count, v_count, H_ACTIVE, V_ACTIVE);
  assign w_win    = (v_count >= 16'(V_ACTIVE)) || !w_active || !rd_req;
`endif

  // A read in the same cycle always takes the port.
  assign w_grant_wr = w_buf_full && w_win && !rd_req;

  board_wr_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_buf (
    .clk        (clk_25MHz),
    .rst        (rst),
    .i_wr_valid (wr_valid),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .i_commit   (w_grant_wr),
    .o_full     (w_buf_full),
    .o_addr     (w_buf_addr),
    .o_data     (w_buf_data)
  );

  // ---------------------------------------------------------------------------
  // RAM port, read-token pipeline and frame pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      r_vld_pipe    <= '0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wdata   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[RD_STAGES-2:0], rd_req};
      r_frame_start <= (h_count == 16'd0) && (v_count == 16'd0);
      if (rd_req) begin
        r_mem_addr <= rd_addr;
        r_mem_we   <= 1'b0;
      end else if (w_grant_wr) begin
        r_mem_addr  <= w_buf_addr;
        r_mem_wdata <= w_buf_data;
        r_mem_we    <= 1'b1;
      end else begin
        // Idle: address and write data hold to avoid needless toggling.
        r_mem_we <= 1'b0;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign rd_valid    = r_vld_pipe[RD_STAGES-1];
  assign rd_data     = mem_rdata;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_board_mem_arbiter.sv
module tb_board_mem_arbiter;

  logic        clk_25MHz = 1'b0;
  logic        rst;
  logic [15:0] h_count, v_count;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic        frame_start;

  int n_pass  = 0;
  int n_total = 0;

  board_mem_arbiter dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .h_count     (h_count),
    .v_count     (v_count),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .frame_start (frame_start)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Board RAM: synchronous read, write on mem_we.
  logic [3:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 4'((i * 7) & 15);
    ram[8'h2A] = 4'h7;
    mem_rdata  = 4'h0;
  end
  always @(posedge clk_25MHz) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic drive(input logic [15:0] h, input logic [15:0] v, input logic rd,
                       input logic [7:0] ra, input logic wv, input logic [7:0] wa,
                       input logic [3:0] wd);
    h_count = h; v_count = v; rd_req = rd; rd_addr = ra;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
  endtask

  typedef struct {
    logic [15:0] h, v;
    logic        rd;
    logic [7:0]  ra;
    logic        wv;
    logic [7:0]  wa;
    logic [3:0]  wd;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [3:0]  e_wdata;
    logic        e_rdv;
    logic [3:0]  e_rdata;
    logic        e_rdy;
    logic        e_fs;
  } vec_t;

  // Reference model state (transaction level: pending write, read-data delay
  // line, RAM image).
  logic [3:0] mram [256];
  logic       m_full;
  logic [7:0] m_baddr;
  logic [3:0] m_bdata;
  logic [7:0] m_addr;
  logic [3:0] m_wdata;
  logic       m_we;
  logic       m_fs;
  logic [1:0] m_rv;
  logic [3:0] m_rd [2];

  function automatic logic model_win(input logic [15:0] h, input logic [15:0] v, input logic rd);
`ifdef BOARD_ARB_VBLANK_ONLY_EN
    return v >= 16'd480;
`else
    return !rd;
`endif
  endfunction

  initial begin
    vec_t vt [9];
    int   cnt, pulses, ok;
    logic [15:0] hh, vv, ph, pv;
    logic [3:0]  wexp [4];
    logic [7:0]  aseq [4];
    logic        cap, rd_now;

    drive(16'd0, 16'd0, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0);
    rst = 1'b1;
    tick(); tick();
    // ---- reset state
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_wr_ready", 32'(wr_ready), 32'h1);

`ifndef BOARD_ARB_VBLANK_ONLY_EN
    // ---- table: read latency, write capture/commit, read-vs-write priority
    //           h    v   rd  ra    wv  wa    wd    we  addr  wdat rdv rdat rdy fs
    vt[0] = '{100, 50, 1, 8'h2A, 0, 8'h00, 4'h0, 0, 8'h2A, 4'h0, 0, 4'h0, 1, 0};
    vt[1] = '{101, 50, 0, 8'h00, 1, 8'h10, 4'h9, 0, 8'h2A, 4'h0, 1, 4'h7, 0, 0};
    vt[2] = '{102, 50, 1, 8'h05, 0, 8'h00, 4'h0, 0, 8'h05, 4'h0, 0, 4'h0, 0, 0};
    vt[3] = '{103, 50, 0, 8'h00, 0, 8'h00, 4'h0, 1, 8'h10, 4'h9, 1, 4'h3, 1, 0};
    vt[4] = '{104, 50, 0, 8'h00, 1, 8'h11, 4'h3, 0, 8'h10, 4'h9, 0, 4'h0, 0, 0};
    vt[5] = '{700, 50, 0, 8'h00, 1, 8'h11, 4'h3, 1, 8'h11, 4'h3, 0, 4'h0, 1, 0};
    vt[6] = '{  0,  0, 0, 8'h00, 0, 8'h00, 4'h0, 0, 8'h11, 4'h3, 0, 4'h0, 1, 1};
    vt[7] = '{  1,  0, 1, 8'h10, 0, 8'h00, 4'h0, 0, 8'h10, 4'h3, 0, 4'h0, 1, 0};
    vt[8] = '{  2,  0, 0, 8'h00, 0, 8'h00, 4'h0, 0, 8'h10, 4'h3, 1, 4'h9, 1, 0};
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].h, vt[i].v, vt[i].rd, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].wd);
      tick();
      chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].e_wdata));
      chk($sformatf("vec%0d_rdv", i), 32'(rd_valid), 32'(vt[i].e_rdv));
      if (vt[i].e_rdv) chk($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'(vt[i].e_rdata));
      chk($sformatf("vec%0d_rdy", i), 32'(wr_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vt[i].e_fs));
    end
`endif

    // ---- reset mid-frame with the buffer FULL
    drive(16'd200, 16'd100, 1'b1, 8'h03, 1'b1, 8'h44, 4'h5);
    tick();
    chk("rstfull_captured", 32'(wr_ready), 32'h0);
    wr_valid = 1'b0;
    tick();
    #5 rst = 1'b1;
    #1;
    chk("rstfull_async_we", 32'(mem_we), 32'h0);
    chk("rstfull_async_addr", 32'(mem_addr), 32'h0);
    chk("rstfull_async_rdy", 32'(wr_ready), 32'h0);
    chk("rstfull_async_rdv", 32'(rd_valid), 32'h0);
    rd_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rstfull_rel_rdy", 32'(wr_ready), 32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      h_count = 16'(210 + i);
      v_count = 16'd490;
      tick();
      if (mem_we) cnt++;
    end
    chk("rstfull_no_we_after", 32'(cnt), 32'h0);

`ifndef BOARD_ARB_VBLANK_ONLY_EN
    // ---- contention: a full active line of reads blocks the write
    drive(16'd0, 16'd100, 1'b1, 8'h00, 1'b1, 8'h10, 4'h9);
    cnt = 0;
    for (int i = 0; i < 640; i++) begin
      h_count = 16'(i);
      rd_addr = 8'(i);
      tick();
      wr_valid = 1'b0;
      if (mem_we) cnt++;
    end
    chk("cont_no_we", 32'(cnt), 32'h0);
    chk("cont_still_full", 32'(wr_ready), 32'h0);
    drive(16'd640, 16'd100, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0);
    tick();
    chk("cont_commit_we", 32'(mem_we), 32'h1);
    chk("cont_commit_addr", 32'(mem_addr), 32'h10);
    chk("cont_commit_data", 32'(mem_wdata), 32'h9);
`else
    // ---- vblank-only: write offered in active video waits for line 480
    drive(16'd0, 16'd10, 1'b0, 8'h00, 1'b1, 8'h20, 4'h6);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      h_count = 16'(i * 13);
      tick();
      wr_valid = 1'b0;
      if (mem_we) cnt++;
    end
    v_count = 16'd479;
    for (int i = 790; i < 800; i++) begin
      h_count = 16'(i);
      tick();
      if (mem_we) cnt++;
    end
    chk("vbl_no_early_we", 32'(cnt), 32'h0);
    v_count = 16'd480;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      h_count = 16'(i);
      tick();
      if (mem_we && mem_addr == 8'h20 && mem_wdata == 4'h6) cnt++;
    end
    chk("vbl_commit", 32'(cnt), 32'h1);
`endif

    // ---- back-to-back writes in blanking
    drive(16'd10, 16'd490, 1'b0, 8'h00, 1'b1, 8'h01, 4'h1);
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    wexp = '{1'b0, 1'b1, 1'b0, 1'b1};
    aseq = '{8'h01, 8'h01, 8'h02, 8'h02};
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = aseq[i];
      wr_data  = 4'(aseq[i]);
      h_count  = 16'(20 + i);
      tick();
      chk($sformatf("b2b%0d_we", i), 32'(mem_we), 32'(wexp[i]));
      chk($sformatf("b2b%0d_rdy", i), 32'(wr_ready), 32'(wexp[i]));
      if (wexp[i]) chk($sformatf("b2b%0d_addr", i), 32'(mem_addr), 32'(aseq[i]));
    end
    wr_valid = 1'b0;
    tick();

    // ---- frame_start across the raster wrap
    hh = 16'd790; vv = 16'd524; pulses = 0; ok = 0;
    for (int i = 0; i < 30; i++) begin
      h_count = hh; v_count = vv; ph = hh; pv = vv;
      tick();
      if (frame_start) begin
        pulses++;
        if (ph == 16'd0 && pv == 16'd0) ok++;
      end
      if (hh == 16'd799) begin
        hh = 16'd0;
        vv = (vv == 16'd524) ? 16'd0 : vv + 16'd1;
      end else hh = hh + 16'd1;
    end
    chk("fs_pulses", 32'(pulses), 32'h1);
    chk("fs_position", 32'(ok), 32'h1);

    // ---- randomized run against the reference model
    rst = 1'b1;
    drive(16'd0, 16'd1, 1'b0, 8'h00, 1'b0, 8'h00, 4'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mram[i] = ram[i];
    m_full = 1'b0; m_baddr = '0; m_bdata = '0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0; m_fs = 1'b0;
    m_rv = '0; m_rd[0] = '0; m_rd[1] = '0;
    rd_now = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) begin
        hh = 16'd0; vv = 16'd0;
      end else begin
        hh = 16'($urandom_range(799));
        vv = 16'($urandom_range(524));
      end
      // reads come in bursts, as a renderer would issue them
      if ($urandom_range(7) == 0) rd_now = !rd_now;
      drive(hh, vv, rd_now, 8'($urandom), ($urandom_range(1) == 1), 8'($urandom), 4'($urandom));

      cap = wr_valid && !m_full;
      m_rv[1] = m_rv[0]; m_rd[1] = m_rd[0];
      m_rv[0] = rd_req;  m_rd[0] = mram[rd_addr];
      if (rd_req) begin
        m_addr = rd_addr; m_we = 1'b0;
      end else if (m_full && model_win(hh, vv, rd_req)) begin
        m_addr = m_baddr; m_wdata = m_bdata; m_we = 1'b1;
        mram[m_baddr] = m_bdata;
        m_full = 1'b0;
      end else m_we = 1'b0;
      if (cap) begin
        m_full = 1'b1; m_baddr = wr_addr; m_bdata = wr_data;
      end
      m_fs = (hh == 16'd0) && (vv == 16'd0);

      tick();
      chk($sformatf("rnd%0d_port", c), {17'h0, mem_we, mem_addr, mem_wdata, rd_valid, wr_ready, frame_start},
          {17'h0, m_we, m_addr, m_wdata, m_rv[1], !m_full, m_fs});
      if (m_rv[1]) chk($sformatf("rnd%0d_rdata", c), 32'(rd_data), 32'(m_rd[1]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
